// File: rtl/ann_pkg.sv
// Shared types and helpers for the three-layer ANN sequencer: FSM states,
// default datapath sizes and the seven-segment digit encoder.
package ann_pkg;

   localparam int DW_DEFAULT         = 16;
   localparam int IMAGE_SIZE_DEFAULT = 16;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_CLR,
      S_MAC,
      S_WAIT,
      S_CAPT,
      S_CLASS,
      S_DONE
   } state_t;

   // Pattern is {dp,g,f,e,d,c,b,a}, active-high; anything that is not a digit blanks the display.
   function automatic logic [7:0] seg_encode(input logic [3:0] value);
      logic [7:0] seg;
      case (value)
         4'd0:    seg = 8'h3F;
         4'd1:    seg = 8'h06;
         4'd2:    seg = 8'h5B;
         4'd3:    seg = 8'h4F;
         4'd4:    seg = 8'h66;
         4'd5:    seg = 8'h6D;
         4'd6:    seg = 8'h7D;
         4'd7:    seg = 8'h07;
         4'd8:    seg = 8'h7F;
         4'd9:    seg = 8'h6F;
         default: seg = 8'h00;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/ann_argmax.sv
// Sequential signed max-tracker fed one candidate per enabled cycle.
// best_idx already accounts for the candidate presented this cycle.
module ann_argmax
   import ann_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int IW = 4
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] value,
   input  logic [IW-1:0] index,
   output logic [IW-1:0] best_idx
);

   logic [DW-1:0] best_val;
   logic [IW-1:0] held_idx;
   logic          take;

   // clr seeds the search with the current candidate; strict greater-than keeps the earliest winner on ties.
   always_comb begin
      take = en && (clr || ($signed(value) > $signed(best_val)));
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         best_val <= '0;
         held_idx <= '0;
      end else if (take) begin
         best_val <= value;
         held_idx <= index;
      end
   end

   assign best_idx = take ? index : held_idx;

endmodule

// File: rtl/ann_layer_sequencer.sv
// Sequences image load, per-layer coefficient fetch, MAC sweeps and output capture
// for the three-layer node array, then picks the winning class and drives the display.
module ann_layer_sequencer
   import ann_pkg::*;
#(
   parameter int IMAGE_SIZE = IMAGE_SIZE_DEFAULT,
   parameter int L1         = 16,
   parameter int L2         = 4,
   parameter int L3         = 10,
   parameter int DW         = DW_DEFAULT
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     start,
   input  logic [IMAGE_SIZE*DW-1:0] image,
   input  logic [IMAGE_SIZE*DW-1:0] node_out,
   input  logic                     coef_ack,
   output logic                     coef_req,
   output logic [1:0]               coef_layer,
   output logic                     acc_clr,
   output logic                     mac_en,
   output logic [6:0]               mac_idx,
   output logic [IMAGE_SIZE*DW-1:0] pipe_data,
   output logic                     busy,
   output logic                     done,
   output logic [3:0]               digit,
   output logic [7:0]               seven_seg
);

   localparam logic [6:0] FAN0       = 7'(IMAGE_SIZE);
   localparam logic [6:0] FAN1       = 7'(L1);
   localparam logic [6:0] FAN2       = 7'(L2);
   localparam logic [3:0] LAST_CLASS = 4'(L3 - 1);

   state_t        state;
   state_t        next_state;
   logic [1:0]    layer;
   logic [3:0]    cls_idx;
   logic [6:0]    fan_in;
   int            node_cnt;
   logic [DW-1:0] pipe [IMAGE_SIZE];
   logic [3:0]    best_idx;
   logic          cls_first;
   logic          cls_en;

   assign coef_layer = layer;

   // Fan-in sets the MAC sweep length; node count sets how many lanes survive capture.
   always_comb begin
      fan_in   = FAN2;
      node_cnt = L3;
      case (layer)
         2'd0: begin
            fan_in   = FAN0;
            node_cnt = L1;
         end
         2'd1: begin
            fan_in   = FAN1;
            node_cnt = L2;
         end
         default: begin
            fan_in   = FAN2;
            node_cnt = L3;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      coef_req   = 1'b0;
      acc_clr    = 1'b0;
      mac_en     = 1'b0;
      case (state)
         S_IDLE:  if (start) next_state = S_LOAD;
         S_LOAD:  next_state = S_REQ;
         S_REQ: begin
            coef_req = 1'b1;
            if (coef_ack) next_state = S_CLR;
         end
         S_CLR: begin
            acc_clr    = 1'b1;
            next_state = S_MAC;
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (mac_idx == fan_in - 7'd1) next_state = S_WAIT;
         end
         S_WAIT:  next_state = S_CAPT;
         S_CAPT:  next_state = (layer == 2'd2) ? S_CLASS : S_REQ;
         S_CLASS: if (cls_idx == LAST_CLASS) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Registered outputs and the shared pipeline register; busy/done look ahead so they line up with the state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         layer     <= '0;
         mac_idx   <= '0;
         cls_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         digit     <= '0;
         seven_seg <= '0;
         for (int i = 0; i < IMAGE_SIZE; i++) pipe[i] <= '0;
      end else begin
         busy <= (next_state != S_IDLE);
         done <= (next_state == S_DONE);
         case (state)
            S_LOAD: begin
               for (int i = 0; i < IMAGE_SIZE; i++) pipe[i] <= image[i*DW +: DW];
               layer     <= '0;
               digit     <= '0;
               seven_seg <= '0;
            end
            S_CLR: mac_idx <= '0;
            S_MAC: if (next_state == S_MAC) mac_idx <= mac_idx + 7'd1;
            S_CAPT: begin
               for (int i = 0; i < IMAGE_SIZE; i++) begin
                  pipe[i] <= (i < node_cnt) ? node_out[i*DW +: DW] : '0;
               end
               if (layer != 2'd2) layer <= layer + 2'd1;
               cls_idx <= '0;
            end
            S_CLASS: begin
               cls_idx <= cls_idx + 4'd1;
               if (next_state == S_DONE) begin
                  digit     <= best_idx;
                  seven_seg <= seg_encode(best_idx);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < IMAGE_SIZE; i++) pipe_data[i*DW +: DW] = pipe[i];
   end

   assign cls_en    = (state == S_CLASS);
   assign cls_first = cls_en && (cls_idx == 4'd0);

   ann_argmax #(
      .DW (DW),
      .IW (4)
   ) u_argmax (
      .clk      (clk),
      .n_rst    (n_rst),
      .clr      (cls_first),
      .en       (cls_en),
      .value    (pipe[cls_idx]),
      .index    (cls_idx),
      .best_idx (best_idx)
   );

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed scoreboard bench for ann_layer_sequencer: expected class, display pattern and
// done cycle are queued at start and popped when done fires.
module tb_ann_layer_sequencer;

   localparam int IS  = 16;
   localparam int DW  = 16;
   localparam int PW  = IS * DW;
   localparam int L3N = 10;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          start;
   logic          coef_ack;
   logic [PW-1:0] image;
   logic [PW-1:0] node_out;
   logic          coef_req;
   logic [1:0]    coef_layer;
   logic          acc_clr;
   logic          mac_en;
   logic [6:0]    mac_idx;
   logic [PW-1:0] pipe_data;
   logic          busy;
   logic          done;
   logic [3:0]    digit;
   logic [7:0]    seven_seg;

   int compared   = 0;
   int mismatched = 0;

   logic [DW-1:0] nodeTab [3][IS];
   logic [DW-1:0] imageTab [IS];
   logic [7:0]    segTab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
   int            expDigitQ[$];
   int            expDoneQ[$];

   always #5 clk = ~clk;

   ann_layer_sequencer dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .image      (image),
      .node_out   (node_out),
      .coef_ack   (coef_ack),
      .coef_req   (coef_req),
      .coef_layer (coef_layer),
      .acc_clr    (acc_clr),
      .mac_en     (mac_en),
      .mac_idx    (mac_idx),
      .pipe_data  (pipe_data),
      .busy       (busy),
      .done       (done),
      .digit      (digit),
      .seven_seg  (seven_seg)
   );

   task automatic checkOutput(input string tag, input logic [PW-1:0] observed, input logic [PW-1:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [PW-1:0] packLayer(input int layer, input int keep);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < keep; i++) r[i*DW +: DW] = nodeTab[layer][i];
      return r;
   endfunction

   function automatic logic [PW-1:0] packImage();
      logic [PW-1:0] r;
      for (int i = 0; i < IS; i++) r[i*DW +: DW] = imageTab[i];
      return r;
   endfunction

   // Pipeline contents expected when coefficients for a layer are first requested.
   function automatic logic [PW-1:0] expectedPipe(input int layer);
      if (layer == 0) return packImage();
      if (layer == 1) return packLayer(0, 16);
      return packLayer(1, 4);
   endfunction

   function automatic int modelArgmax();
      int best;
      best = 0;
      for (int k = 1; k < L3N; k++) begin
         if ($signed(nodeTab[2][k]) > $signed(nodeTab[2][best])) best = k;
      end
      return best;
   endfunction

   task automatic setClasses(input int c0, input int c1, input int c2, input int c3, input int c4,
                             input int c5, input int c6, input int c7, input int c8, input int c9);
      int vals[10];
      vals = '{c0, c1, c2, c3, c4, c5, c6, c7, c8, c9};
      for (int k = 0; k < L3N; k++) nodeTab[2][k] = 16'(vals[k]);
      for (int k = L3N; k < IS; k++) nodeTab[2][k] = 16'h7FFF;
   endtask

   // ackDelay 0 ties coef_ack high; otherwise ack rises after coef_req has been held ackDelay cycles.
   task automatic applyStimulus(input int ackDelay, input bit disturb, input bit abortRun);
      int expDone;
      int cycle;
      int reqLayer;
      int reqCount;
      int macModel;
      int doneSeen;
      int macCount[3];
      bit prevReq;
      int popDigit;
      int popDone;

      expDone  = 60 + 3 * ackDelay;
      reqLayer = -1;
      reqCount = 0;
      macModel = 0;
      doneSeen = 0;
      prevReq  = 1'b0;
      macCount = '{0, 0, 0};
      if (!abortRun) begin
         expDigitQ.push_back(modelArgmax());
         expDoneQ.push_back(expDone);
      end

      @(negedge clk);
      image    = packImage();
      node_out = packLayer(0, IS);
      coef_ack = (ackDelay == 0);
      start    = 1'b1;
      @(posedge clk);
      cycle = 0;
      while (cycle < expDone + 4) begin
         @(negedge clk);
         cycle++;
         start = 1'b0;
         if (coef_layer < 2'd3) node_out = packLayer(int'(coef_layer), IS);
         checkOutput("busy", busy, cycle <= expDone);

         if (coef_req) begin
            if (!prevReq) begin
               reqLayer++;
               reqCount = 0;
               checkOutput("req_pipe", pipe_data, expectedPipe(reqLayer));
            end
            reqCount++;
            checkOutput("coef_layer", coef_layer, reqLayer);
         end else if (prevReq) begin
            checkOutput("req_len", reqCount, (ackDelay == 0) ? 1 : ackDelay + 1);
         end
         prevReq = coef_req;
         if (ackDelay > 0) coef_ack = coef_req && (reqCount > ackDelay);

         if (acc_clr) macModel = 0;
         if (mac_en) begin
            checkOutput("mac_idx", mac_idx, macModel);
            macModel++;
            if (coef_layer < 2'd3) macCount[coef_layer]++;
            if (disturb && coef_layer == 2'd0 && mac_idx == 7'd5) begin
               start    = 1'b1;
               coef_ack = 1'b1;
            end
            if (abortRun && coef_layer == 2'd1 && mac_idx == 7'd5) begin
               n_rst = 1'b0;
               #1;
               checkOutput("abort_ctl", {coef_req, coef_layer, acc_clr, mac_en, mac_idx, busy, done}, '0);
               checkOutput("abort_result", {digit, seven_seg}, '0);
               checkOutput("abort_pipe", pipe_data, '0);
               @(negedge clk);
               n_rst    = 1'b1;
               coef_ack = 1'b0;
               return;
            end
         end

         if (done) begin
            doneSeen++;
            if (expDigitQ.size() > 0) begin
               popDigit = expDigitQ.pop_front();
               popDone  = expDoneQ.pop_front();
               checkOutput("done_cycle", cycle, popDone);
               checkOutput("digit", digit, popDigit);
               checkOutput("seven_seg", seven_seg, segTab[popDigit]);
               checkOutput("final_pipe", pipe_data, packLayer(2, L3N));
            end else begin
               checkOutput("done_queue", expDigitQ.size(), 1);
            end
         end
      end
      checkOutput("done_count", doneSeen, 1);
      checkOutput("layers_requested", reqLayer, 2);
      checkOutput("mac_count_l0", macCount[0], 16);
      checkOutput("mac_count_l1", macCount[1], 16);
      checkOutput("mac_count_l2", macCount[2], 4);
   endtask

   initial begin
      n_rst    = 1'b0;
      start    = 1'b0;
      coef_ack = 1'b0;
      image    = '0;
      node_out = '0;
      for (int i = 0; i < IS; i++) begin
         imageTab[i]   = 16'(3 * i + 1);
         nodeTab[0][i] = 16'(100 + i);
         nodeTab[1][i] = 16'(200 + i);
      end
      setClasses(5, -2, 9, 9, 0, 0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      checkOutput("reset_ctl", {coef_req, coef_layer, acc_clr, mac_en, mac_idx, busy, done}, '0);
      checkOutput("reset_result", {digit, seven_seg}, '0);
      checkOutput("reset_pipe", pipe_data, '0);
      n_rst = 1'b1;
      @(negedge clk);

      $display("[TB] run 1: ack tied high, tie between classes 2 and 3");
      applyStimulus(0, 1'b0, 1'b0);

      $display("[TB] run 2: ack delayed 3 cycles, start and ack poked during MAC, all negative");
      setClasses(-100, -101, -102, -103, -104, -105, -106, -3, -108, -109);
      applyStimulus(3, 1'b1, 1'b0);

      $display("[TB] run 3: reset during layer 1 MAC");
      setClasses(5, -2, 9, 9, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1'b0, 1'b1);

      $display("[TB] run 4: full inference after reset, all classes equal");
      setClasses(37, 37, 37, 37, 37, 37, 37, 37, 37, 37);
      applyStimulus(0, 1'b0, 1'b0);

      checkOutput("queue_drained", expDigitQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ann_layer_sequencer.md
Name: ann_layer_sequencer

Overview:
- Sequences the three-layer ANN datapath: loads the image into the shared pipeline register, requests per-layer coefficients, and drives accumulator clear/MAC enable/input index to the node array.
- Captures node outputs back into the pipeline register between layers, zero-filling unused lanes.
- After layer 3, runs a sequential argmax over the L3 outputs, latches the winning class, and drives the seven-segment display.

Parameters:
- IMAGE_SIZE, 16, pipeline register lanes = layer-1 fan-in
- L1, 16, layer-1 node count (layer-2 fan-in); L1 <= IMAGE_SIZE
- L2, 4, layer-2 node count (layer-3 fan-in); L2 <= IMAGE_SIZE
- L3, 10, layer-3 node count (classes); L3 <= IMAGE_SIZE, L3 <= 16
- DW, 16, data width, two's complement

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  image+weights loaded; sampled only in IDLE
- image  in  IMAGE_SIZE*DW  flattened image; lane i = bits [i*DW +: DW]
- node_out  in  IMAGE_SIZE*DW  flattened node outputs, valid 1 cycle after last MAC
- coef_ack  in  1  coefficient bank ready for coef_layer
- coef_req  out  1  request coefficient bank
- coef_layer  out  2  layer whose coefficients are requested (0..2)
- acc_clr  out  1  clear node accumulators
- mac_en  out  1  node MAC enable
- mac_idx  out  7  input index for current MAC
- pipe_data  out  IMAGE_SIZE*DW  pipeline register contents to nodes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result valid
- digit  out  4  winning class index
- seven_seg  out  8  {dp,g,f,e,d,c,b,a}, active-high

Behaviour:
- Reset values: all outputs 0; pipe all zeros; layer=0; state IDLE. Reset mid-operation aborts immediately to IDLE.
- FSM: IDLE, LOAD, REQ, CLR, MAC, WAIT, CAPT, CLASS, DONE.
- IDLE: start=1 -> LOAD. start is ignored while busy.
- LOAD (1 cycle): pipe <= image; layer <= 0 -> REQ.
- REQ: coef_req=1, coef_layer=layer (stable while req is high). Stay until coef_ack=1, then -> CLR. coef_ack outside REQ is ignored. An ack already high on REQ entry is accepted in the same cycle.
- CLR (1 cycle): acc_clr=1 -> MAC; mac_idx <= 0.
- MAC (F cycles): mac_en=1, mac_idx = 0..F-1, incrementing each cycle. F = IMAGE_SIZE / L1 / L2 for layer 0/1/2. After idx F-1 -> WAIT.
- WAIT (1 cycle): covers node latency -> CAPT.
- CAPT (1 cycle): pipe[i] <= node_out[i] for i < N, else 0. N = L1 / L2 / L3 for layer 0/1/2.
  - Layer < 2: layer++ -> REQ.
  - Layer 2: -> CLASS.
- CLASS (L3 cycles): cycle k compares pipe[k] (signed) against running max; starts with best=pipe[0], idx=0. Strictly greater replaces, so ties keep the lowest index. -> DONE.
- DONE (1 cycle): done=1; digit and seven_seg update on entry and hold until next LOAD -> IDLE.
- Seven-seg encoding 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F; any other value gives 00. dp is always 0.
- Latency with coef_ack tied high, defaults: LOAD 1 + layers (20+20+8) + CLASS 10 + DONE → done high in cycle 60 after the start-sampling edge.
- Outputs are registered except coef_req, acc_clr and mac_en, which decode from state.

Decomposition:
- ann_pkg holds:
  - State enum
  - Default DW/IMAGE_SIZE constants
  - Function seg_encode(logic [3:0]) returning 8-bit pattern
- Sub-module ann_argmax (sequential max-tracker: clr, en, value, index in; best_idx out) instantiated once.

Test Plan:
- Reset mid-MAC (layer 1, idx 5) → all outputs 0 next cycle; start after reset runs a full inference normally.
- coef_ack tied 1, start pulse → coef_layer 0,1,2 in order; mac_idx sweeps 0..15, 0..15, 0..3; done in cycle 60; busy high cycles 1..60.
- coef_ack delayed 3 cycles per layer → coef_req held 4 cycles each, coef_layer stable; done delayed to cycle 69.
- Model node_out = lane values; layer-2 capture of 4 → pipe lanes 4..15 read 0 after CAPT.
- Final layer outputs {5,-2,9,9,0,...} → digit=2, seven_seg=8'h5B. All equal → digit 0, seg 3F. All negative with max at lane 7 → digit 7, seg 07.
- start asserted while busy and coef_ack pulsed in MAC → no state change, no extra done.
